operand_cache: RTL and testbench



---
 rtl/cache_pkg.sv | 24 ++
 rtl/operand_cache_if.sv | 31 +++
 rtl/operand_cache_array.sv | 58 +++++
 rtl/operand_cache.sv | 258 +++++++++++++++++++++++++
 tb/tb_operand_cache.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the operand cache: FSM encoding, default widths and
// the helper that locates the remote/local selector bit in an address.
package cache_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int ADDR_W_DEFAULT = 5;

    // Address bit that selects remote (1) or local (0) storage.
    localparam int REMOTE_BIT = ADDR_W_DEFAULT - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_MEM = 3'd1,
        ST_RD1    = 3'd2,
        ST_RD2    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Remote selector position for an arbitrary address width.
    function automatic int remote_bit(input int aw);
        return aw - 1;
    endfunction

endpackage

// File: rtl/operand_cache_if.sv
// External data-memory port of the operand cache: a single outstanding
// request held until the cycle it is acknowledged.
interface operand_cache_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/operand_cache_array.sv
// Local register storage: NREG x XLEN, two asynchronous read ports and one
// synchronous write port. Indices at or beyond NREG read as zero and are
// never written.
module operand_cache_array #(
    parameter int XLEN           = 32,
    parameter int IDX_W          = 4,
    parameter int NREG           = 16,
    parameter bit RESET_IDENTITY = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] raddr1,
    input  logic [IDX_W-1:0] raddr2,
    output logic [XLEN-1:0]  rdata1,
    output logic [XLEN-1:0]  rdata2,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata
);
    localparam logic [IDX_W:0] NREG_L = (IDX_W + 1)'(NREG);

    logic [XLEN-1:0] regs_r [NREG];
    logic            we_ok_s;

    // Range-checked asynchronous reads and write qualification.
    always_comb begin
        rdata1  = {XLEN{1'b0}};
        rdata2  = {XLEN{1'b0}};
        we_ok_s = 1'b0;
        if ({1'b0, raddr1} < NREG_L) begin
            rdata1 = regs_r[raddr1];
        end else begin
            rdata1 = {XLEN{1'b0}};
        end
        if ({1'b0, raddr2} < NREG_L) begin
            rdata2 = regs_r[raddr2];
        end else begin
            rdata2 = {XLEN{1'b0}};
        end
        if (we && ({1'b0, waddr} < NREG_L)) begin
            we_ok_s = 1'b1;
        end else begin
            we_ok_s = 1'b0;
        end
    end

    // Storage update: reset pattern on RESET, otherwise the single write port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= RESET_IDENTITY ? XLEN'(i) : {XLEN{1'b0}};
            end
        end else if (we_ok_s) begin
            regs_r[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/operand_cache.sv
// Operand cache between decode and the ALU. Local addresses are served from
// the register array (with same-cycle write bypass); addresses with the MSB
// set go to external memory, during which the pipeline is held via busy.
module operand_cache
    import cache_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int NREG           = 16,
    parameter bit RESET_IDENTITY = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              op_valid,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              rs1_en,
    input  logic              rs2_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]   DataWr,
    output logic [XLEN-1:0]   RUrs1,
    output logic [XLEN-1:0]   RUrs2,
    output logic              op_done,
    output logic              busy,
    operand_cache_if.master   bus
);
    localparam int RBIT  = remote_bit(ADDR_W);
    localparam int IDX_W = ADDR_W - 1;
    localparam logic [IDX_W:0] NREG_L = (IDX_W + 1)'(NREG);

    state_e            state_r, state_nxt_s;

    // Request decode
    logic              idle_s, acc_rd_s, acc_wr_s;
    logic              wr_rem_s, wr_loc_s, rd_ok_s;
    logic              rs1_rem_s, rs2_rem_s;
    logic [XLEN-1:0]   arr1_s, arr2_s, loc1_s, loc2_s;

    // Captured request
    logic [ADDR_W-1:0] rs1_c_r, rs2_c_r, rd_c_r;
    logic [ADDR_W-1:0] rs1_c_nxt_s, rs2_c_nxt_s, rd_c_nxt_s;
    logic              rd_pend_r, rs1_rem_r, rs2_rem_r;
    logic              rd_pend_nxt_s, rs1_rem_nxt_s, rs2_rem_nxt_s;

    // Registered outputs
    logic [XLEN-1:0]   ru1_r, ru2_r, ru1_nxt_s, ru2_nxt_s;
    logic              op_done_r, busy_r, mem_req_r, mem_we_r;
    logic              mem_req_nxt_s, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [XLEN-1:0]   mem_wdata_r, mem_wdata_nxt_s;

    operand_cache_array #(
        .XLEN          (XLEN),
        .IDX_W         (IDX_W),
        .NREG          (NREG),
        .RESET_IDENTITY(RESET_IDENTITY)
    ) u_array (
        .CLK   (CLK),
        .RESET (RESET),
        .raddr1(rs1[IDX_W-1:0]),
        .raddr2(rs2[IDX_W-1:0]),
        .rdata1(arr1_s),
        .rdata2(arr2_s),
        .we    (wr_loc_s),
        .waddr (rd[IDX_W-1:0]),
        .wdata (DataWr)
    );

    // Accept decode and local operand values, bypassing a same-cycle local write.
    always_comb begin
        idle_s    = (state_r == ST_IDLE);
        acc_rd_s  = idle_s && op_valid;
        acc_wr_s  = idle_s && wr_en;
        wr_rem_s  = acc_wr_s && rd[RBIT];
        rd_ok_s   = ({1'b0, rd[IDX_W-1:0]} < NREG_L) && (rd != {ADDR_W{1'b0}});
        wr_loc_s  = acc_wr_s && !rd[RBIT] && rd_ok_s;
        rs1_rem_s = rs1_en && rs1[RBIT];
        rs2_rem_s = rs2_en && rs2[RBIT];
        loc1_s    = {XLEN{1'b0}};
        loc2_s    = {XLEN{1'b0}};
        if (!rs1_en || rs1[RBIT]) begin
            loc1_s = {XLEN{1'b0}};
        end else if (wr_loc_s && (rs1 == rd)) begin
            loc1_s = DataWr;
        end else begin
            loc1_s = arr1_s;
        end
        if (!rs2_en || rs2[RBIT]) begin
            loc2_s = {XLEN{1'b0}};
        end else if (wr_loc_s && (rs2 == rd)) begin
            loc2_s = DataWr;
        end else begin
            loc2_s = arr2_s;
        end
    end

    // Next state, capture registers and next values of the registered outputs.
    always_comb begin
        state_nxt_s     = state_r;
        rs1_c_nxt_s     = rs1_c_r;
        rs2_c_nxt_s     = rs2_c_r;
        rd_c_nxt_s      = rd_c_r;
        rd_pend_nxt_s   = rd_pend_r;
        rs1_rem_nxt_s   = rs1_rem_r;
        rs2_rem_nxt_s   = rs2_rem_r;
        ru1_nxt_s       = ru1_r;
        ru2_nxt_s       = ru2_r;
        mem_wdata_nxt_s = mem_wdata_r;
        mem_req_nxt_s   = 1'b0;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = mem_addr_r;

        case (state_r)
            ST_IDLE: begin
                if (acc_rd_s || acc_wr_s) begin
                    rs1_c_nxt_s = rs1;
                    rs2_c_nxt_s = rs2;
                    rd_c_nxt_s  = rd;
                    if (acc_rd_s) begin
                        rd_pend_nxt_s = 1'b1;
                        rs1_rem_nxt_s = rs1_rem_s;
                        rs2_rem_nxt_s = rs2_rem_s;
                        ru1_nxt_s     = loc1_s;
                        ru2_nxt_s     = loc2_s;
                    end else begin
                        rd_pend_nxt_s = 1'b0;
                        rs1_rem_nxt_s = 1'b0;
                        rs2_rem_nxt_s = 1'b0;
                    end
                    if (wr_rem_s) begin
                        mem_wdata_nxt_s = DataWr;
                        state_nxt_s     = ST_WR_MEM;
                    end else if (acc_rd_s && rs1_rem_s) begin
                        state_nxt_s = ST_RD1;
                    end else if (acc_rd_s && rs2_rem_s) begin
                        state_nxt_s = ST_RD2;
                    end else if (acc_rd_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_MEM: begin
                if (bus.mem_ack) begin
                    if (!rd_pend_r) begin
                        state_nxt_s = ST_IDLE;
                    end else if (rs1_rem_r) begin
                        state_nxt_s = ST_RD1;
                    end else if (rs2_rem_r) begin
                        state_nxt_s = ST_RD2;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_WR_MEM;
                end
            end
            ST_RD1: begin
                if (bus.mem_ack) begin
                    ru1_nxt_s   = bus.mem_rdata;
                    state_nxt_s = rs2_rem_r ? ST_RD2 : ST_DONE;
                end else begin
                    state_nxt_s = ST_RD1;
                end
            end
            ST_RD2: begin
                if (bus.mem_ack) begin
                    ru2_nxt_s   = bus.mem_rdata;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RD2;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Memory request follows the state being entered, so address and
        // direction switch exactly on the ack edge of a chained access.
        case (state_nxt_s)
            ST_WR_MEM: begin
                mem_req_nxt_s  = 1'b1;
                mem_we_nxt_s   = 1'b1;
                mem_addr_nxt_s = rd_c_nxt_s;
            end
            ST_RD1: begin
                mem_req_nxt_s  = 1'b1;
                mem_we_nxt_s   = 1'b0;
                mem_addr_nxt_s = rs1_c_nxt_s;
            end
            ST_RD2: begin
                mem_req_nxt_s  = 1'b1;
                mem_we_nxt_s   = 1'b0;
                mem_addr_nxt_s = rs2_c_nxt_s;
            end
            default: begin
                mem_req_nxt_s  = 1'b0;
                mem_we_nxt_s   = 1'b0;
                mem_addr_nxt_s = mem_addr_r;
            end
        endcase
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            rs1_c_r     <= {ADDR_W{1'b0}};
            rs2_c_r     <= {ADDR_W{1'b0}};
            rd_c_r      <= {ADDR_W{1'b0}};
            rd_pend_r   <= 1'b0;
            rs1_rem_r   <= 1'b0;
            rs2_rem_r   <= 1'b0;
            ru1_r       <= {XLEN{1'b0}};
            ru2_r       <= {XLEN{1'b0}};
            op_done_r   <= 1'b0;
            busy_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            rs1_c_r     <= rs1_c_nxt_s;
            rs2_c_r     <= rs2_c_nxt_s;
            rd_c_r      <= rd_c_nxt_s;
            rd_pend_r   <= rd_pend_nxt_s;
            rs1_rem_r   <= rs1_rem_nxt_s;
            rs2_rem_r   <= rs2_rem_nxt_s;
            ru1_r       <= ru1_nxt_s;
            ru2_r       <= ru2_nxt_s;
            op_done_r   <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
        end
    end

    assign RUrs1         = ru1_r;
    assign RUrs2         = ru2_r;
    assign op_done       = op_done_r;
    assign busy          = busy_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_operand_cache.sv
// Directed testbench for operand_cache (NREG=12 so that local index 13 is
// out of range).
module tb_operand_cache;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 12;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              op_valid, rs1_en, rs2_en, wr_en;
    logic [ADDR_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   DataWr, RUrs1, RUrs2;
    logic              op_done, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int req_cyc   = 0;
    logic [5:0]  req_log   [$];
    logic [31:0] wdata_log [$];

    operand_cache_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_if ();

    operand_cache #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .NREG(NREG), .RESET_IDENTITY(1'b1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .op_valid(op_valid),
        .rs1(rs1), .rs2(rs2), .rs1_en(rs1_en), .rs2_en(rs2_en),
        .wr_en(wr_en), .rd(rd), .DataWr(DataWr),
        .RUrs1(RUrs1), .RUrs2(RUrs2), .op_done(op_done), .busy(busy),
        .bus(bus_if)
    );

    always #5 CLK = ~CLK;

    // Record completed memory transfers, done pulses and request cycles.
    always @(posedge CLK) begin
        if (bus_if.mem_req && bus_if.mem_ack) begin
            req_log.push_back({bus_if.mem_we, bus_if.mem_addr});
            wdata_log.push_back(bus_if.mem_wdata);
        end
        if (op_done) done_cnt <= done_cnt + 1;
        if (bus_if.mem_req) req_cyc <= req_cyc + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; op_valid = 1'b0; wr_en = 1'b0; rs1_en = 1'b1; rs2_en = 1'b1;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; DataWr = 32'd0;
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'd0;
        tick(); tick();
        total_cnt++; if (RUrs1 !== 32'd0) $display("FAIL reset_rurs1: got %h want %h", RUrs1, 32'd0); else pass_cnt++;
        total_cnt++; if (RUrs2 !== 32'd0) $display("FAIL reset_rurs2: got %h want %h", RUrs2, 32'd0); else pass_cnt++;
        total_cnt++; if ({op_done, busy, bus_if.mem_req, bus_if.mem_we} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want %b", {op_done, busy, bus_if.mem_req, bus_if.mem_we}, 4'b0000); else pass_cnt++;
        total_cnt++; if (bus_if.mem_addr !== 5'd0) $display("FAIL reset_addr: got %h want %h", bus_if.mem_addr, 5'd0); else pass_cnt++;
        total_cnt++; if (bus_if.mem_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want %h", bus_if.mem_wdata, 32'd0); else pass_cnt++;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_local_read();
        op_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd7;
        tick();
        op_valid = 1'b0;
        total_cnt++; if ({op_done, busy} !== 2'b11) $display("FAIL local_done: got %b want %b", {op_done, busy}, 2'b11); else pass_cnt++;
        total_cnt++; if (RUrs1 !== 32'd3) $display("FAIL local_rs1: got %h want %h", RUrs1, 32'd3); else pass_cnt++;
        total_cnt++; if (RUrs2 !== 32'd7) $display("FAIL local_rs2: got %h want %h", RUrs2, 32'd7); else pass_cnt++;
        tick();
        total_cnt++; if ({op_done, busy} !== 2'b00) $display("FAIL local_idle: got %b want %b", {op_done, busy}, 2'b00); else pass_cnt++;
        total_cnt++; if (RUrs1 !== 32'd3) $display("FAIL local_hold: got %h want %h", RUrs1, 32'd3); else pass_cnt++;
        total_cnt++; if (req_cyc !== 0) $display("FAIL local_noreq: got %0d want %0d", req_cyc, 0); else pass_cnt++;
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; rd = 5'd5; DataWr = 32'hDEADBEEF;
        op_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6;
        tick();
        wr_en = 1'b0; op_valid = 1'b0;
        total_cnt++; if (RUrs1 !== 32'hDEADBEEF) $display("FAIL bypass_rs1: got %h want %h", RUrs1, 32'hDEADBEEF); else pass_cnt++;
        total_cnt++; if (RUrs2 !== 32'd6) $display("FAIL bypass_rs2: got %h want %h", RUrs2, 32'd6); else pass_cnt++;
        tick();
        wr_en = 1'b1; rd = 5'd0; DataWr = 32'h12345678;
        tick();
        wr_en = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL wr_only_busy: got %b want %b", busy, 1'b0); else pass_cnt++;
        op_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd5;
        tick();
        op_valid = 1'b0;
        total_cnt++; if (RUrs1 !== 32'd0) $display("FAIL reg0_write_dropped: got %h want %h", RUrs1, 32'd0); else pass_cnt++;
        total_cnt++; if (RUrs2 !== 32'hDEADBEEF) $display("FAIL reg5_kept: got %h want %h", RUrs2, 32'hDEADBEEF); else pass_cnt++;
        tick();
        wr_en = 1'b1; rd = 5'd13; DataWr = 32'h5555AAAA;
        op_valid = 1'b1; rs1 = 5'd13; rs2 = 5'd7; rs2_en = 1'b0;
        tick();
        wr_en = 1'b0; op_valid = 1'b0; rs2_en = 1'b1;
        total_cnt++; if (RUrs1 !== 32'd0) $display("FAIL out_of_range: got %h want %h", RUrs1, 32'd0); else pass_cnt++;
        total_cnt++; if (RUrs2 !== 32'd0) $display("FAIL rs2_disabled: got %h want %h", RUrs2, 32'd0); else pass_cnt++;
        tick();
    endtask

    task automatic test_remote_read();
        int d0;
        d0 = done_cnt;
        op_valid = 1'b1; rs1 = 5'h12; rs2 = 5'd2;
        tick();
        op_valid = 1'b0;
        total_cnt++; if ({bus_if.mem_req, bus_if.mem_we, busy} !== 3'b101)
            $display("FAIL rd1_req: got %b want %b", {bus_if.mem_req, bus_if.mem_we, busy}, 3'b101); else pass_cnt++;
        total_cnt++; if (bus_if.mem_addr !== 5'h12) $display("FAIL rd1_addr: got %h want %h", bus_if.mem_addr, 5'h12); else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++; if ({op_done, bus_if.mem_req, bus_if.mem_addr} !== {1'b0, 1'b1, 5'h12})
            $display("FAIL rd1_wait: got %b want %b", {op_done, bus_if.mem_req, bus_if.mem_addr}, {1'b0, 1'b1, 5'h12}); else pass_cnt++;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hCAFE0001;
        tick();
        bus_if.mem_ack = 1'b0;
        total_cnt++; if ({op_done, bus_if.mem_req} !== 2'b10) $display("FAIL rd1_done_n5: got %b want %b", {op_done, bus_if.mem_req}, 2'b10); else pass_cnt++;
        total_cnt++; if (done_cnt !== d0) $display("FAIL rd1_early_done: got %0d want %0d", done_cnt, d0); else pass_cnt++;
        total_cnt++; if (RUrs1 !== 32'hCAFE0001) $display("FAIL rd1_rurs1: got %h want %h", RUrs1, 32'hCAFE0001); else pass_cnt++;
        total_cnt++; if (RUrs2 !== 32'd2) $display("FAIL rd1_rurs2: got %h want %h", RUrs2, 32'd2); else pass_cnt++;
        tick();
    endtask

    task automatic test_remote_write_chain();
        int s0, d0, busy_low;
        bit got_done;
        logic [5:0] e0, e1, e2;
        logic [31:0] w0;
        s0 = req_log.size(); d0 = done_cnt; busy_low = 0; got_done = 1'b0;
        wr_en = 1'b1; rd = 5'h1F; DataWr = 32'hA5A50000;
        op_valid = 1'b1; rs1 = 5'h10; rs2 = 5'h11;
        tick();
        wr_en = 1'b0; op_valid = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            if (op_done) begin
                got_done = 1'b1;
            end else begin
                if (!busy) busy_low++;
                if (bus_if.mem_req && !bus_if.mem_ack) begin
                    bus_if.mem_ack = 1'b1;
                    bus_if.mem_rdata = 32'hC0DE0000 | {27'd0, bus_if.mem_addr};
                end else begin
                    bus_if.mem_ack = 1'b0;
                end
                tick();
            end
        end
        bus_if.mem_ack = 1'b0;
        e0 = (req_log.size() > s0)     ? req_log[s0]     : 6'h3F;
        e1 = (req_log.size() > s0 + 1) ? req_log[s0 + 1] : 6'h3F;
        e2 = (req_log.size() > s0 + 2) ? req_log[s0 + 2] : 6'h3F;
        w0 = (wdata_log.size() > s0)   ? wdata_log[s0]   : 32'hFFFFFFFF;
        total_cnt++; if (got_done !== 1'b1) $display("FAIL chain_timeout: got %b want %b", got_done, 1'b1); else pass_cnt++;
        total_cnt++; if (busy_low !== 0) $display("FAIL chain_busy: got %0d low cycles want %0d", busy_low, 0); else pass_cnt++;
        total_cnt++; if (req_log.size() - s0 !== 3) $display("FAIL chain_count: got %0d want %0d", req_log.size() - s0, 3); else pass_cnt++;
        total_cnt++; if (e0 !== {1'b1, 5'h1F}) $display("FAIL chain_req0: got %h want %h", e0, {1'b1, 5'h1F}); else pass_cnt++;
        total_cnt++; if (e1 !== {1'b0, 5'h10}) $display("FAIL chain_req1: got %h want %h", e1, {1'b0, 5'h10}); else pass_cnt++;
        total_cnt++; if (e2 !== {1'b0, 5'h11}) $display("FAIL chain_req2: got %h want %h", e2, {1'b0, 5'h11}); else pass_cnt++;
        total_cnt++; if (w0 !== 32'hA5A50000) $display("FAIL chain_wdata: got %h want %h", w0, 32'hA5A50000); else pass_cnt++;
        total_cnt++; if (RUrs1 !== 32'hC0DE0010) $display("FAIL chain_rurs1: got %h want %h", RUrs1, 32'hC0DE0010); else pass_cnt++;
        total_cnt++; if (RUrs2 !== 32'hC0DE0011) $display("FAIL chain_rurs2: got %h want %h", RUrs2, 32'hC0DE0011); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL chain_done_once: got %0d want %0d", done_cnt - d0, 1); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; rs1 = 5'h15; rs2 = 5'd4;
        tick();
        op_valid = 1'b0;
        total_cnt++; if ({bus_if.mem_req, bus_if.mem_addr} !== {1'b1, 5'h15})
            $display("FAIL rst_mid_req: got %b want %b", {bus_if.mem_req, bus_if.mem_addr}, {1'b1, 5'h15}); else pass_cnt++;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        total_cnt++; if ({busy, bus_if.mem_req, op_done} !== 3'b000)
            $display("FAIL rst_mid_idle: got %b want %b", {busy, bus_if.mem_req, op_done}, 3'b000); else pass_cnt++;
        total_cnt++; if ({RUrs1, RUrs2} !== 64'd0) $display("FAIL rst_mid_outs: got %h want %h", {RUrs1, RUrs2}, 64'd0); else pass_cnt++;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hFFFFFFFF;
        tick();
        bus_if.mem_ack = 1'b0;
        total_cnt++; if ({busy, bus_if.mem_req, op_done} !== 3'b000)
            $display("FAIL late_ack: got %b want %b", {busy, bus_if.mem_req, op_done}, 3'b000); else pass_cnt++;
        total_cnt++; if (RUrs1 !== 32'd0) $display("FAIL late_ack_data: got %h want %h", RUrs1, 32'd0); else pass_cnt++;
        op_valid = 1'b1; rs1 = 5'd4; rs2 = 5'd5;
        tick();
        op_valid = 1'b0;
        total_cnt++; if (RUrs1 !== 32'd4) $display("FAIL rst_reg4: got %h want %h", RUrs1, 32'd4); else pass_cnt++;
        total_cnt++; if (RUrs2 !== 32'd5) $display("FAIL rst_reg5_reinit: got %h want %h", RUrs2, 32'd5); else pass_cnt++;
        tick();
    endtask

    task automatic test_busy_ignore();
        int d0;
        d0 = done_cnt;
        op_valid = 1'b1; rs1 = 5'h1A; rs2 = 5'd1;
        tick();
        op_valid = 1'b1; wr_en = 1'b1; rd = 5'd6; DataWr = 32'h00000077; rs1 = 5'd2; rs2 = 5'd3;
        tick();
        op_valid = 1'b0; wr_en = 1'b0;
        total_cnt++; if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr} !== {2'b10, 5'h1A})
            $display("FAIL busy_addr_hold: got %b want %b", {bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr}, {2'b10, 5'h1A}); else pass_cnt++;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h12345678;
        tick();
        bus_if.mem_ack = 1'b0;
        total_cnt++; if (op_done !== 1'b1) $display("FAIL busy_done: got %b want %b", op_done, 1'b1); else pass_cnt++;
        total_cnt++; if ({RUrs1, RUrs2} !== {32'h12345678, 32'd1})
            $display("FAIL busy_operands: got %h want %h", {RUrs1, RUrs2}, {32'h12345678, 32'd1}); else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL busy_done_once: got %0d want %0d", done_cnt - d0, 1); else pass_cnt++;
        bus_if.mem_ack = 1'b1;
        tick();
        bus_if.mem_ack = 1'b0;
        total_cnt++; if ({busy, bus_if.mem_req, op_done} !== 3'b000)
            $display("FAIL stray_ack: got %b want %b", {busy, bus_if.mem_req, op_done}, 3'b000); else pass_cnt++;
        op_valid = 1'b1; rs1 = 5'd6; rs2 = 5'd1;
        tick();
        op_valid = 1'b0;
        total_cnt++; if (RUrs1 !== 32'd6) $display("FAIL busy_write_ignored: got %h want %h", RUrs1, 32'd6); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_local_read();
        test_bypass();
        test_remote_read();
        test_remote_write_chain();
        test_reset_mid();
        test_busy_ignore();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
